// File: rtl/falling_piece_ctrl.sv
// Falling-piece controller: spawns a piece of the selected type at the top of
// the playfield, moves it under gravity and player pulses, validates each
// candidate move with the grid checker and hands landed pieces to the lock stage.
module falling_piece_ctrl #(
  parameter int ROWS          = 20,
  parameter int COLS          = 10,
  parameter int GRAVITY_TICKS = 1000000
) (
  input  logic                     clk,
  input  logic                     nRst_i,
  input  logic [2:0]               block_type_i,
  input  logic                     spawn_req_i,
  input  logic                     move_left_i,
  input  logic                     move_right_i,
  input  logic                     soft_drop_i,
  output logic                     probe_valid_o,
  output logic [$clog2(ROWS)-1:0]  probe_row_o,
  output logic [$clog2(COLS)-1:0]  probe_col_o,
  input  logic                     probe_ack_i,
  input  logic                     probe_hit_i,
  output logic                     lock_valid_o,
  input  logic                     lock_ready_i,
  output logic [$clog2(ROWS)-1:0]  row_o,
  output logic [$clog2(COLS)-1:0]  col_o,
  output logic [2:0]               type_o,
  output logic                     active_o,
  output logic                     game_over_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int GW = $clog2(GRAVITY_TICKS);

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0] SPAWN_COL = CW'(COLS / 2 - 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_TICKS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPAWN = 3'd1;
  localparam logic [2:0] ST_FALL  = 3'd2;
  localparam logic [2:0] ST_PROBE = 3'd3;
  localparam logic [2:0] ST_LAND  = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [GW-1:0] grav_q, grav_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [2:0]    type_q, type_d;
  logic [RW-1:0] cand_row_q, cand_row_d;
  logic [CW-1:0] cand_col_q, cand_col_d;
  logic          cand_down_q, cand_down_d;

  // Next-state logic: move arbitration, boundary checks and handshakes.
  always_comb begin
    state_d     = state_q;
    grav_d      = grav_q;
    row_d       = row_q;
    col_d       = col_q;
    type_d      = type_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    cand_down_d = cand_down_q;

    case (state_q)
      ST_IDLE: begin
        if (spawn_req_i) begin
          // Type 7 is not a real piece; treat it as the single-cell DOT.
          type_d  = (block_type_i == 3'd7) ? 3'd3 : block_type_i;
          row_d   = '0;
          col_d   = SPAWN_COL;
          state_d = ST_SPAWN;
        end
      end

      ST_SPAWN: begin
        if (probe_ack_i) begin
          state_d = probe_hit_i ? ST_OVER : ST_FALL;
        end
      end

      ST_FALL: begin
        if ((grav_q == GRAV_LAST) || soft_drop_i) begin
          // Down wins; any lateral pulse in this cycle is discarded.
          grav_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = ST_LAND;
          end else begin
            cand_row_d  = row_q + RW'(1);
            cand_col_d  = col_q;
            cand_down_d = 1'b1;
            state_d     = ST_PROBE;
          end
        end else begin
          grav_d = grav_q + GW'(1);
          if (move_left_i) begin
            if (col_q != '0) begin
              cand_row_d  = row_q;
              cand_col_d  = col_q - CW'(1);
              cand_down_d = 1'b0;
              state_d     = ST_PROBE;
            end
          end else if (move_right_i) begin
            if (col_q != COL_LAST) begin
              cand_row_d  = row_q;
              cand_col_d  = col_q + CW'(1);
              cand_down_d = 1'b0;
              state_d     = ST_PROBE;
            end
          end
        end
      end

      ST_PROBE: begin
        // Gravity counter holds; move and spawn pulses are dropped here.
        if (probe_ack_i) begin
          if (!probe_hit_i) begin
            row_d   = cand_row_q;
            col_d   = cand_col_q;
            state_d = ST_FALL;
          end else begin
            state_d = cand_down_q ? ST_LAND : ST_FALL;
          end
        end
      end

      ST_LAND: begin
        if (lock_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_OVER: begin
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q     <= ST_IDLE;
      grav_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      type_q      <= 3'd4;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      cand_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grav_q      <= grav_d;
      row_q       <= row_d;
      col_q       <= col_d;
      type_q      <= type_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cand_down_q <= cand_down_d;
    end
  end

  // The spawn check probes the current position; move checks probe the candidate.
  assign probe_valid_o = (state_q == ST_SPAWN) || (state_q == ST_PROBE);
  assign probe_row_o   = (state_q == ST_PROBE) ? cand_row_q : row_q;
  assign probe_col_o   = (state_q == ST_PROBE) ? cand_col_q : col_q;
  assign lock_valid_o  = (state_q == ST_LAND);
  assign active_o      = (state_q == ST_FALL) || (state_q == ST_PROBE);
  assign game_over_o   = (state_q == ST_OVER);
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign type_o        = type_q;

endmodule

// File: tb/tb_falling_piece_ctrl.sv
// Bench for falling_piece_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural reference model.
module tb_falling_piece_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int GT   = 4;

  logic       clk = 1'b0;
  logic       nRst_i;
  logic [2:0] block_type_i;
  logic       spawn_req_i, move_left_i, move_right_i, soft_drop_i;
  logic       probe_valid_o;
  logic [1:0] probe_row_o, probe_col_o;
  logic       probe_ack_i, probe_hit_i;
  logic       lock_valid_o, lock_ready_i;
  logic [1:0] row_o, col_o;
  logic [2:0] type_o;
  logic       active_o, game_over_o;

  falling_piece_ctrl #(.ROWS(ROWS), .COLS(COLS), .GRAVITY_TICKS(GT)) dut (
    .clk(clk), .nRst_i(nRst_i), .block_type_i(block_type_i),
    .spawn_req_i(spawn_req_i), .move_left_i(move_left_i),
    .move_right_i(move_right_i), .soft_drop_i(soft_drop_i),
    .probe_valid_o(probe_valid_o), .probe_row_o(probe_row_o),
    .probe_col_o(probe_col_o), .probe_ack_i(probe_ack_i),
    .probe_hit_i(probe_hit_i), .lock_valid_o(lock_valid_o),
    .lock_ready_i(lock_ready_i), .row_o(row_o), .col_o(col_o),
    .type_o(type_o), .active_o(active_o), .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int spawn, bt, left, right, sd, ack, hit, rdy;
    int pv, prow, pcol, lock, act, over, row, col, typ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int spawn, bt, left, right, sd, ack, hit, rdy,
                              input int pv, prow, pcol, lock, act, over, row, col, typ);
    vec_t v;
    v.spawn = spawn; v.bt = bt; v.left = left; v.right = right; v.sd = sd;
    v.ack = ack; v.hit = hit; v.rdy = rdy;
    v.pv = pv; v.prow = prow; v.pcol = pcol; v.lock = lock; v.act = act;
    v.over = over; v.row = row; v.col = col; v.typ = typ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int pv, prow, pcol, lock, act, over,
                            input int row, col, typ);
    chk({tag, ".probe_valid"}, 32'(probe_valid_o), pv);
    if (pv != 0) begin
      chk({tag, ".probe_row"}, 32'(probe_row_o), prow);
      chk({tag, ".probe_col"}, 32'(probe_col_o), pcol);
    end
    chk({tag, ".lock_valid"}, 32'(lock_valid_o), lock);
    chk({tag, ".active"}, 32'(active_o), act);
    chk({tag, ".game_over"}, 32'(game_over_o), over);
    chk({tag, ".row"}, 32'(row_o), row);
    chk({tag, ".col"}, 32'(col_o), col);
    chk({tag, ".type"}, 32'(type_o), typ);
  endtask

  task automatic drive(input int sp, bt, l, r, sd, ack, hit, rdy);
    spawn_req_i  = sp[0];
    block_type_i = bt[2:0];
    move_left_i  = l[0];
    move_right_i = r[0];
    soft_drop_i  = sd[0];
    probe_ack_i  = ack[0];
    probe_hit_i  = hit[0];
    lock_ready_i = rdy[0];
  endtask

  // One clock: inputs applied at the falling edge, outputs settle after the rising edge.
  task automatic step(input int sp, bt, l, r, sd, ack, hit, rdy);
    @(negedge clk);
    drive(sp, bt, l, r, sd, ack, hit, rdy);
    @(posedge clk);
    #1;
  endtask

  // Reference model: piece described by its mode, position and pending candidate.
  localparam int M_IDLE = 0, M_SPAWN = 1, M_FALL = 2, M_CHECK = 3, M_LAND = 4, M_OVER = 5;
  int m_mode, m_row, m_col, m_type, m_ticks, m_crow, m_ccol, m_down, m_locks;

  task automatic model_reset();
    m_mode = M_IDLE; m_row = 0; m_col = 0; m_type = 4; m_ticks = 0;
    m_crow = 0; m_ccol = 0; m_down = 0;
  endtask

  task automatic model_step();
    int dx;
    case (m_mode)
      M_IDLE: if (spawn_req_i) begin
        m_type = (block_type_i == 3'd7) ? 3 : int'(block_type_i);
        m_row  = 0;
        m_col  = COLS / 2 - 1;
        m_mode = M_SPAWN;
      end
      M_SPAWN: if (probe_ack_i) m_mode = probe_hit_i ? M_OVER : M_FALL;
      M_FALL: begin
        if (soft_drop_i || m_ticks == GT - 1) begin
          m_ticks = 0;
          if (m_row == ROWS - 1) m_mode = M_LAND;
          else begin
            m_crow = m_row + 1; m_ccol = m_col; m_down = 1; m_mode = M_CHECK;
          end
        end else begin
          m_ticks++;
          dx = move_left_i ? -1 : (move_right_i ? 1 : 0);
          if (dx != 0 && m_col + dx >= 0 && m_col + dx < COLS) begin
            m_crow = m_row; m_ccol = m_col + dx; m_down = 0; m_mode = M_CHECK;
          end
        end
      end
      M_CHECK: if (probe_ack_i) begin
        if (!probe_hit_i) begin
          m_row = m_crow; m_col = m_ccol; m_mode = M_FALL;
        end else begin
          m_mode = (m_down != 0) ? M_LAND : M_FALL;
        end
      end
      M_LAND: if (lock_ready_i) begin
        m_locks++;
        $display("lock %0d: type=%0d row=%0d col=%0d", m_locks, m_type, m_row, m_col);
        m_mode = M_IDLE;
      end
      default: ;
    endcase
  endtask

  initial begin
    nRst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_locks = 0;

    // Directed table: inputs for one cycle and outputs expected after that edge.
    //              sp bt l r sd ak ht rd | pv pr pc lk ac ov rw cl ty
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, 2)); // spawn type 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 2)); // spawn clear
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 1, 0, 0, 1, 2)); // gravity probe
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 1, 1, 2)); // commit row 1
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 1, 1, 2)); // left probe
    vecs.push_back(mk(1, 6, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0, 1, 1, 2)); // pulses dropped
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 2)); // commit col 0
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 1, 0, 2)); // left at edge, stray ack
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0,  1, 2, 0, 0, 1, 0, 1, 0, 2)); // down beats right
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 2, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  1, 2, 1, 0, 1, 0, 2, 0, 2)); // right probe
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 2, 0, 2)); // lateral hit
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 3, 0, 0, 1, 0, 2, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 3, 0, 2)); // bottom row
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 3, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 3, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 3, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3, 0, 2)); // land, no probe
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3, 0, 2)); // spawn ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 3, 0, 2)); // lock accepted
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 3, 0, 2)); // stray ready
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, 3)); // type 7 -> 3
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 1, 0, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 1, 3)); // down hit -> land
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0, 1, 5)); // blocked spawn
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1, 0, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, 5));

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 4);
    @(negedge clk);
    nRst_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].spawn, vecs[i].bt, vecs[i].left, vecs[i].right, vecs[i].sd,
           vecs[i].ack, vecs[i].hit, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].pv, vecs[i].prow, vecs[i].pcol,
                 vecs[i].lock, vecs[i].act, vecs[i].over, vecs[i].row, vecs[i].col,
                 vecs[i].typ);
      $display("vec %0d: pv=%0d prow=%0d pcol=%0d lock=%0d act=%0d over=%0d row=%0d col=%0d type=%0d",
               i, probe_valid_o, probe_row_o, probe_col_o, lock_valid_o, active_o,
               game_over_o, row_o, col_o, type_o);
    end

    // Only reset leaves game over.
    @(negedge clk);
    nRst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_outs("rst_over", 0, 0, 0, 0, 0, 0, 0, 0, 4);
    @(negedge clk);
    nRst_i = 1'b1;

    // Delayed ack on a lateral probe: outputs held, gravity counter frozen.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_outs("s6.spawn", 1, 0, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check_outs("s6.fall", 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("s6.tick1", 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check_outs("s6.right", 1, 0, 2, 0, 1, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_outs($sformatf("s6.hold%0d", k), 1, 0, 2, 0, 1, 0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check_outs("s6.commit", 0, 0, 0, 0, 1, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("s6.tick3", 0, 0, 0, 0, 1, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("s6.grav", 1, 1, 2, 0, 1, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("s6.wait", 1, 1, 2, 0, 1, 0, 0, 2, 0);
    @(negedge clk);
    nRst_i = 1'b0;
    #1;
    check_outs("s6.rst_now", 0, 0, 0, 0, 0, 0, 0, 0, 4);
    @(posedge clk);
    #1;
    check_outs("s6.rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 4);
    @(negedge clk);
    nRst_i = 1'b1;
    $display("seq6: delayed ack and mid-probe reset done");

    // Randomized traffic against the reference model.
    model_reset();
    begin
      int over_cycles = 0;
      for (int c = 0; c < 4000 && bad < 20; c++) begin
        @(negedge clk);
        nRst_i = !((over_cycles > 3) || ($urandom_range(0, 299) == 0));
        drive(($urandom_range(0, 3) == 0) ? 1 : 0,
              int'($urandom_range(0, 7)),
              ($urandom_range(0, 5) == 0) ? 1 : 0,
              ($urandom_range(0, 5) == 0) ? 1 : 0,
              ($urandom_range(0, 7) == 0) ? 1 : 0,
              probe_valid_o ? (($urandom_range(0, 2) == 0) ? 1 : 0)
                            : (($urandom_range(0, 7) == 0) ? 1 : 0),
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              ($urandom_range(0, 2) == 0) ? 1 : 0);
        if (!nRst_i) model_reset();
        @(posedge clk);
        if (nRst_i) model_step();
        #1;
        over_cycles = (m_mode == M_OVER) ? over_cycles + 1 : 0;
        check_outs($sformatf("rnd%0d", c),
                   (m_mode == M_SPAWN || m_mode == M_CHECK) ? 1 : 0,
                   (m_mode == M_CHECK) ? m_crow : m_row,
                   (m_mode == M_CHECK) ? m_ccol : m_col,
                   (m_mode == M_LAND) ? 1 : 0,
                   (m_mode == M_FALL || m_mode == M_CHECK) ? 1 : 0,
                   (m_mode == M_OVER) ? 1 : 0,
                   m_row, m_col, m_type);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/falling_piece_ctrl.md
Name: falling_piece_ctrl

Overview:
Downstream consumer of the block-select counter. On a spawn request it latches the selected block type (0..6), places the piece at the top of the playfield, and moves it down under a gravity timer and left/right/soft-drop pulses. Every candidate move is checked against the playfield through a probe handshake. When a downward move is blocked, the landed piece is handed to the grid-lock stage through a valid/ready handshake.

Parameters:
ROWS, 20, playfield height in rows; row 0 is the top.
COLS, 10, playfield width in columns.
GRAVITY_TICKS, 1000000, clk cycles per automatic one-row drop; minimum 2.

Ports:
clk  input  1  system clock
nRst_i  input  1  asynchronous active-low reset
block_type_i  input  3  block type from the select counter, sampled on spawn
spawn_req_i  input  1  single-cycle pulse requesting a new piece
move_left_i  input  1  single-cycle pulse, already synchronized
move_right_i  input  1  single-cycle pulse, already synchronized
soft_drop_i  input  1  single-cycle pulse, already synchronized
probe_valid_o  output  1  candidate position presented to the grid checker
probe_row_o  output  $clog2(ROWS)  candidate row
probe_col_o  output  $clog2(COLS)  candidate column
probe_ack_i  input  1  checker result valid; any latency of 1 or more cycles
probe_hit_i  input  1  candidate collides; sampled only with probe_ack_i
lock_valid_o  output  1  landed piece is available to lock
lock_ready_i  input  1  lock stage accepts the piece
row_o  output  $clog2(ROWS)  current piece row
col_o  output  $clog2(COLS)  current piece column
type_o  output  3  current piece type
active_o  output  1  a piece is falling (FALL or PROBE state)
game_over_o  output  1  sticky; spawn position was blocked

Behaviour:
- Reset is asynchronous, active-low, on nRst_i; clock is clk. Reset values:
  - state IDLE; gravity count 0
  - row_o 0, col_o 0, type_o 3'd4 (square, which matches the upstream reset type)
  - all valid outputs, active_o and game_over_o are 0
- States: IDLE, SPAWN, FALL, PROBE, LAND, OVER.
- IDLE: spawn_req_i moves to SPAWN on the next edge.
  - type_o <= block_type_i; value 7 maps to 3 (DOT).
  - row_o <= 0; col_o <= COLS/2-1.
- SPAWN: drives probe_valid_o=1 with the current row/col.
  - Ack with hit goes to OVER.
  - Ack with no hit goes to FALL.
- FALL:
  - The gravity counter increments every cycle.
  - Down move is requested when the counter reaches GRAVITY_TICKS-1 or soft_drop_i=1. The counter clears to 0 on that request.
  - Priority within one cycle: down > left > right. Lower-priority pulses in the same cycle are discarded.
  - Down with row_o==ROWS-1 goes straight to LAND with no probe.
  - Left with col_o==0, or right with col_o==COLS-1, is ignored with no probe.
  - Otherwise the candidate is registered and the block enters PROBE. probe_valid_o rises in the first PROBE cycle.
- PROBE:
  - probe_valid_o, probe_row_o and probe_col_o are held stable until probe_ack_i.
  - The gravity counter is frozen.
  - All move and spawn pulses arriving in PROBE are dropped.
  - On ack with no hit: commit the candidate to row_o/col_o and return to FALL.
  - On ack with hit and a down move: go to LAND.
  - On ack with hit and a lateral move: return to FALL with the position unchanged.
  - probe_valid_o deasserts in the cycle after the ack.
- LAND: lock_valid_o=1 with row_o/col_o/type_o stable until lock_ready_i. On the accept edge the block goes to IDLE and lock_valid_o drops. lock_ready_i seen while lock_valid_o=0 is ignored.
- OVER: game_over_o=1. Only reset leaves OVER; all inputs are ignored.
- spawn_req_i outside IDLE is ignored; requests are not queued.
- probe_ack_i while probe_valid_o=0 is ignored.
- Reset in any state, mid-handshake included, returns to the reset values immediately. No pending probe or lock survives.
- Row and column arithmetic is unsigned at the port widths. No wrap is possible because the boundary checks run before the increment or decrement.

Test Plan:
Every scenario uses ROWS=4, COLS=4, GRAVITY_TICKS=4, so the spawn column is 1.
1. Reset, then spawn_req with block_type_i=2; checker acks next cycle with no hit -> type_o=2, row 0, col 1, active_o=1. After 4 cycles probe_row_o=1; ack with no hit -> row_o=1.
2. block_type_i=7 at spawn -> type_o=3.
3. Spawn probe acked with hit=1 -> game_over_o=1 and stays 1. A later spawn_req_i is ignored; only nRst_i clears it.
4. col_o=0 with move_left_i pulsed -> no probe_valid_o, col unchanged. soft_drop_i and move_right_i in the same cycle -> probe is down (row+1), and the right move is lost.
5. Down probe acked with hit -> lock_valid_o=1 holds 3 cycles with lock_ready_i=0. lock_ready_i=1 -> next cycle IDLE and active_o=0. At row 3, a gravity tick goes to LAND without any probe.
6. Ack delayed 5 cycles -> probe outputs stable throughout and gravity counter frozen. Assert nRst_i mid-probe -> all outputs return to reset values, type_o=4.
